// File: rtl/cic_comb_chain_if.sv
// Valid/ready stream bundle for the CIC comb chain: sample input side
// and result output side.
interface cic_comb_chain_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 19,
    parameter int CW        = 1
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic [CW-1:0]               out_chan;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_chan
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_chan
    );
endinterface

// File: rtl/cic_comb_chain.sv
// Multichannel CIC comb chain: STAGES cascaded y[n] = x[n] - x[n-M]
// sections, one register each, with a single global output stall.
module cic_comb_chain #(
    parameter int IN_WIDTH   = 16,
    parameter int STAGES     = 3,
    parameter int DIFF_DELAY = 1,
    parameter int CHANNELS   = 1,
    localparam int OUT_WIDTH = IN_WIDTH + STAGES,
    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input logic             clk,
    input logic             rst,
    input logic             clear,
    cic_comb_chain_if.slave s_if
);
    typedef logic signed [OUT_WIDTH-1:0] word_t;

    logic              flush;
    logic              stall;
    logic              in_fire;
    logic [CW-1:0]     tag_q, tag_d;
    logic [STAGES-1:0] v_q, v_d;
    word_t             d_q [STAGES];
    word_t             d_d [STAGES];
    logic [CW-1:0]     c_q [STAGES];
    logic [CW-1:0]     c_d [STAGES];
    word_t             h_q [STAGES][DIFF_DELAY][CHANNELS];
    word_t             h_d [STAGES][DIFF_DELAY][CHANNELS];

    word_t             x_in  [STAGES];
    word_t             x_old [STAGES];
    logic [STAGES-1:0] x_v;
    logic [CW-1:0]     x_c   [STAGES];

    assign flush   = rst | clear;
    assign stall   = v_q[STAGES-1] & ~s_if.out_ready;
    assign in_fire = s_if.in_valid & ~stall;

    assign s_if.in_ready  = ~stall;
    assign s_if.out_valid = v_q[STAGES-1];
    assign s_if.out_data  = d_q[STAGES-1];
    assign s_if.out_chan  = c_q[STAGES-1];

    always_comb begin : stage_src
        x_in[0] = {{STAGES{s_if.in_data[IN_WIDTH-1]}}, s_if.in_data};
        x_v[0]  = in_fire;
        x_c[0]  = tag_q;
        for (int k = 1; k < STAGES; k++) begin
            x_in[k] = d_q[k-1];
            x_v[k]  = v_q[k-1];
            x_c[k]  = c_q[k-1];
        end
    end

    // Oldest history word of the slot's own channel is the x[n-M] term.
    always_comb begin : hist_sel
        for (int k = 0; k < STAGES; k++) begin
            x_old[k] = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (x_c[k] == CW'(c)) begin
                    x_old[k] = h_q[k][DIFF_DELAY-1][c];
                end
            end
        end
    end

    always_comb begin : next_state
        tag_d = tag_q;
        v_d   = v_q;
        d_d   = d_q;
        c_d   = c_q;
        h_d   = h_q;
        if (!stall) begin
            if (in_fire) begin
                tag_d = (tag_q == CW'(CHANNELS - 1)) ? '0 : tag_q + 1'b1;
            end
            for (int k = 0; k < STAGES; k++) begin
                v_d[k] = x_v[k];
                c_d[k] = x_c[k];
                if (x_v[k]) begin
                    d_d[k] = x_in[k] - x_old[k];
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (x_c[k] == CW'(c)) begin
                            for (int m = DIFF_DELAY - 1; m > 0; m--) begin
                                h_d[k][m][c] = h_q[k][m-1][c];
                            end
                            h_d[k][0][c] = x_in[k];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            tag_q <= '0;
            v_q   <= '0;
            d_q   <= '{default: '0};
            c_q   <= '{default: '0};
            h_q   <= '{default: '0};
        end else begin
            tag_q <= tag_d;
            v_q   <= v_d;
            d_q   <= d_d;
            c_q   <= c_d;
            h_q   <= h_d;
        end
    end
endmodule

// File: tb/tb_cic_comb_chain.sv
// Scoreboard bench: three comb chains (M=1/C=1, M=2/C=1, M=1/C=2)
// share one stimulus stream; a behavioural model predicts each output.
module tb_cic_comb_chain;
    logic clk = 1'b0;
    logic rst, clear, in_valid, out_ready;
    logic signed [15:0] in_data;

    logic [2:0] ov, ir, oc;
    logic signed [18:0] od [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit lat_chk = 1'b0;

    logic signed [18:0] expq [3][$];
    int chq [3][$];
    int stq [3][$];
    logic signed [18:0] logs [3][$];
    int logc [3][$];
    longint tbl [$];

    logic signed [18:0] hist [3][3][2][2];
    int tagm [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int M = (g == 1) ? 2 : 1;
        localparam int C = (g == 2) ? 2 : 1;
        cic_comb_chain_if #(.IN_WIDTH(16), .OUT_WIDTH(19), .CW(1)) ifc ();
        assign ifc.in_valid  = in_valid;
        assign ifc.in_data   = in_data;
        assign ifc.out_ready = out_ready;
        assign ov[g] = ifc.out_valid;
        assign ir[g] = ifc.in_ready;
        assign oc[g] = ifc.out_chan;
        assign od[g] = ifc.out_data;
        cic_comb_chain #(
            .IN_WIDTH(16), .STAGES(3), .DIFF_DELAY(M), .CHANNELS(C)
        ) u_dut (
            .clk(clk), .rst(rst), .clear(clear), .s_if(ifc)
        );
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [18:0] model(input int g, input logic signed [15:0] s);
        int m = (g == 1) ? 2 : 1;
        int nc = (g == 2) ? 2 : 1;
        int ch = tagm[g];
        logic signed [18:0] x, y;
        x = s;
        for (int k = 0; k < 3; k++) begin
            y = x - hist[g][k][m-1][ch];
            if (m == 2) hist[g][k][1][ch] = hist[g][k][0][ch];
            hist[g][k][0][ch] = x;
            x = y;
        end
        tagm[g] = (ch == nc - 1) ? 0 : ch + 1;
        return x;
    endfunction

    always @(negedge clk) begin
        logic signed [18:0] e;
        int c, s;
        for (int g = 0; g < 3; g++) begin
            if (rst || clear) begin
                expq[g].delete();
                chq[g].delete();
                stq[g].delete();
                tagm[g] = 0;
                for (int k = 0; k < 3; k++)
                    for (int m = 0; m < 2; m++)
                        for (int h = 0; h < 2; h++)
                            hist[g][k][m][h] = '0;
            end else begin
                if (ov[g] && out_ready) begin
                    if (expq[g].size() == 0) begin
                        chk($sformatf("d%0d_spurious", g), 1, 0);
                    end else begin
                        e = expq[g].pop_front();
                        c = chq[g].pop_front();
                        s = stq[g].pop_front();
                        chk($sformatf("d%0d_data", g), od[g], e);
                        chk($sformatf("d%0d_chan", g), oc[g], c);
                        if (lat_chk) chk($sformatf("d%0d_lat", g), cyc - s, 3);
                        logs[g].push_back(od[g]);
                        logc[g].push_back(int'(oc[g]));
                    end
                end
                if (ov[g] && !out_ready) begin
                    chk($sformatf("d%0d_stall_rdy", g), ir[g], 0);
                    if (expq[g].size() != 0)
                        chk($sformatf("d%0d_hold", g), od[g], expq[g][0]);
                end
                if (in_valid && ir[g]) begin
                    chq[g].push_back(tagm[g]);
                    stq[g].push_back(cyc);
                    expq[g].push_back(model(g, in_data));
                end
            end
        end
    end

    task automatic send(input logic signed [15:0] s);
        int n = 0;
        in_valid = 1'b1;
        in_data = s;
        @(negedge clk);
        while (!ir[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", int'(n < 200), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit use_clear);
        if (use_clear) clear = 1'b1;
        else rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear = 1'b0;
    endtask

    task automatic clear_logs();
        for (int g = 0; g < 3; g++) begin
            logs[g].delete();
            logc[g].delete();
        end
    endtask

    task automatic chk_log(input int g, input bit wc);
        chk($sformatf("d%0d_loglen", g), logs[g].size(), tbl.size());
        for (int i = 0; i < tbl.size(); i++) begin
            if (i < logs[g].size()) begin
                chk($sformatf("d%0d_log%0d", g, i), logs[g][i], tbl[i]);
                if (wc) chk($sformatf("d%0d_logch%0d", g, i), logc[g][i], i % 2);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("d%0d_rst_valid", g), ov[g], 0);
            chk($sformatf("d%0d_rst_data", g), od[g], 0);
            chk($sformatf("d%0d_rst_chan", g), oc[g], 0);
            chk($sformatf("d%0d_rst_ready", g), ir[g], 1);
        end
        @(posedge clk);
        #1;

        // impulse response, M=1 and M=2
        clear_logs();
        lat_chk = 1'b1;
        send(1);
        repeat (7) send(0);
        drain();
        tbl = '{1, -3, 3, -1, 0, 0, 0, 0};
        chk_log(0, 1'b0);
        tbl = '{1, 0, -3, 0, 3, 0, -1, 0};
        chk_log(1, 1'b0);

        // two interleaved channels
        pulse(1'b0);
        clear_logs();
        for (int i = 0; i < 8; i++) send((i % 2 == 1) ? 16'sd7 : ((i == 0) ? 16'sd1 : 16'sd0));
        drain();
        tbl = '{1, 7, -3, -14, 3, 7, -1, 0};
        chk_log(2, 1'b1);
        lat_chk = 1'b0;

        // five-cycle output stall in a ten-sample stream
        pulse(1'b0);
        fork
            for (int i = 0; i < 10; i++) send(16'(i * 1234 - 5000));
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // full-scale negative constant
        pulse(1'b0);
        clear_logs();
        lat_chk = 1'b1;
        repeat (6) send(-16'sd32768);
        drain();
        tbl = '{-32768, 65536, -32768, 0, 0, 0};
        chk_log(0, 1'b0);
        lat_chk = 1'b0;

        // rst, then clear, with three samples in flight
        for (int r = 0; r < 2; r++) begin
            send(5);
            send(6);
            send(7);
            pulse(r[0]);
            @(negedge clk);
            for (int g = 0; g < 3; g++)
                chk($sformatf("d%0d_flush%0d_valid", g, r), ov[g], 0);
            @(posedge clk);
            #1;
            clear_logs();
            send(1);
            repeat (3) send(0);
            drain();
            tbl = '{1, -3, 3, -1};
            chk_log(0, 1'b0);
        end

        // random traffic with bubbles, back-pressure and a clear
        for (int i = 0; i < 120; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clear = (i == 60);
            @(posedge clk);
            #1;
        end
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
